// File: rtl/muldiv_ctrl.sv
// Iterative mult/multu/div/divu sequencer owning the HI/LO registers.
// Optional MULDIV_EARLY_TERM_EN: multiply leaves RUN once the remaining multiplier bits are zero.
module muldiv_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_con_Start,
    input  logic [2:0]        i_con_Op,
    input  logic [DATA_W-1:0] i_data_A,
    input  logic [DATA_W-1:0] i_data_B,
    output logic              o_con_Busy,
    output logic              o_con_Done,
    output logic              o_con_DivZero,
    output logic [DATA_W-1:0] o_data_Hi,
    output logic [DATA_W-1:0] o_data_Lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [1:0]          state;
    logic [4:0]          cnt;
    logic                is_div;
    logic                neg_q;
    logic                neg_r;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] mcand;
    logic [DATA_W-1:0]   mplier;
    logic [DATA_W-1:0]   dvd;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   divisor;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic                done_q;
    logic                dz_q;

    logic                is_signed;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;
    logic [2*DATA_W-1:0] acc_nx;
    logic [DATA_W-1:0]   mplier_nx;
    logic [DATA_W:0]     rem_sh;
    logic                rem_ge;
    logic [DATA_W-1:0]   rem_nx;
    logic [DATA_W-1:0]   dvd_nx;
    logic                run_last;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quot_fix;
    logic [DATA_W-1:0]   rem_fix;

    // Operand conditioning at issue; abs of the most negative value wraps to itself as unsigned.
    always_comb begin
        is_signed = (i_con_Op == OP_MULT) || (i_con_Op == OP_DIV);
        a_neg     = is_signed && i_data_A[DATA_W-1];
        b_neg     = is_signed && i_data_B[DATA_W-1];
        abs_a     = a_neg ? (~i_data_A + 1'b1) : i_data_A;
        abs_b     = b_neg ? (~i_data_B + 1'b1) : i_data_B;
    end

    always_comb begin
        acc_nx    = mplier[0] ? (acc + mcand) : acc;
        mplier_nx = mplier >> 1;
        rem_sh    = {rem, dvd[DATA_W-1]};
        rem_ge    = rem_sh >= {1'b0, divisor};
        rem_nx    = rem_ge ? (rem_sh[DATA_W-1:0] - divisor) : rem_sh[DATA_W-1:0];
        dvd_nx    = {dvd[DATA_W-2:0], rem_ge};
`ifdef MULDIV_EARLY_TERM_EN
        run_last  = (cnt == 5'd0) || (!is_div && (mplier_nx == '0));
`else
        run_last  = (cnt == 5'd0);
`endif
        prod_fix  = neg_q ? (~acc + 1'b1) : acc;
        quot_fix  = neg_q ? (~dvd + 1'b1) : dvd;
        rem_fix   = neg_r ? (~rem + 1'b1) : rem;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            cnt     <= 5'd0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            dvd     <= '0;
            rem     <= '0;
            divisor <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_con_Start) begin
                        case (i_con_Op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                if (i_con_Op[1] && (i_data_B == '0)) begin
                                    done_q <= 1'b1;
                                    dz_q   <= 1'b1;
                                end else begin
                                    is_div  <= i_con_Op[1];
                                    neg_q   <= a_neg ^ b_neg;
                                    neg_r   <= a_neg;
                                    acc     <= '0;
                                    mcand   <= {{DATA_W{1'b0}}, abs_a};
                                    mplier  <= abs_b;
                                    dvd     <= abs_a;
                                    rem     <= '0;
                                    divisor <= abs_b;
                                    cnt     <= 5'd31;
                                    state   <= S_RUN;
                                end
                            end
                            OP_MTHI: begin
                                hi_q   <= i_data_A;
                                done_q <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_q   <= i_data_A;
                                done_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (is_div) begin
                        rem <= rem_nx;
                        dvd <= dvd_nx;
                    end else begin
                        acc    <= acc_nx;
                        mcand  <= mcand << 1;
                        mplier <= mplier_nx;
                    end
                    cnt <= cnt - 5'd1;
                    if (run_last) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        lo_q <= quot_fix;
                        hi_q <= rem_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_con_Busy    = (state != S_IDLE);
    assign o_con_Done    = done_q;
    assign o_con_DivZero = dz_q;
    assign o_data_Hi     = hi_q;
    assign o_data_Lo     = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI/LO/DivZero queued at issue, checked on Done.
module tb_muldiv_ctrl;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        i_clk;
    logic        i_rst;
    logic        i_con_Start;
    logic [2:0]  i_con_Op;
    logic [31:0] i_data_A;
    logic [31:0] i_data_B;
    logic        o_con_Busy;
    logic        o_con_Done;
    logic        o_con_DivZero;
    logic [31:0] o_data_Hi;
    logic [31:0] o_data_Lo;

    exp_t        scoreboard[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    int          total;
    int          bad;

    muldiv_ctrl #(.DATA_W(32)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_con_Start   (i_con_Start),
        .i_con_Op      (i_con_Op),
        .i_data_A      (i_data_A),
        .i_data_B      (i_data_B),
        .o_con_Busy    (o_con_Busy),
        .o_con_Done    (o_con_Done),
        .o_con_DivZero (o_con_DivZero),
        .o_data_Hi     (o_data_Hi),
        .o_data_Lo     (o_data_Lo)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Number of RUN cycles the sequencer should spend on an accepted op.
    function automatic int runCycles(input logic [2:0] op, input logic [31:0] b);
        int r;
        logic [31:0] ab;
        r = 32;
`ifdef MULDIV_EARLY_TERM_EN
        if (op <= 3'd1) begin
            ab = (op == 3'd0 && b[31]) ? (~b + 32'd1) : b;
            r = 1;
            for (int i = 0; i < 32; i++) if (ab[i]) r = i + 1;
        end
`else
        ab = b;
        if (op > 3'd3 && ab == 32'd0) r = 32;
`endif
        return r;
    endfunction

    task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output exp_t e, output int lat, output int busy);
        logic signed [63:0] sa, sbv, p, q, r;
        logic [63:0] up;
        sa  = $signed({{32{a[31]}}, a});
        sbv = $signed({{32{b[31]}}, b});
        e.hi = model_hi;
        e.lo = model_lo;
        e.dz = 1'b0;
        lat  = runCycles(op, b) + 2;
        busy = runCycles(op, b) + 1;
        case (op)
            3'd0: begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; end
            3'd1: begin up = {32'd0, a} * {32'd0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    e.dz = 1'b1; lat = 1; busy = 0;
                end else if (op == 3'd2) begin
                    q = sa / sbv; r = sa % sbv; e.lo = q[31:0]; e.hi = r[31:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
            3'd4: begin e.hi = a; lat = 1; busy = 0; end
            default: begin e.lo = a; lat = 1; busy = 0; end
        endcase
        model_hi = e.hi;
        model_lo = e.lo;
    endtask

    // Drives Start for exactly one edge (E0) then scrambles operands to prove capture.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge i_clk);
        #1;
        i_con_Start = 1'b1;
        i_con_Op    = op;
        i_data_A    = a;
        i_data_B    = b;
        @(posedge i_clk);
        #1;
        i_con_Start = 1'b0;
        i_data_A    = $urandom;
        i_data_B    = $urandom;
    endtask

    task automatic waitDone(input int lat, input int busy);
        int  n = 0;
        int  nb = 0;
        logic seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge i_clk);
            n++;
            if (o_con_Busy) nb++;
            if (o_con_Done) seen = 1'b1;
        end
        checkOutput("done_seen", {63'd0, seen}, 64'd1);
        checkOutput("latency", n, lat);
        checkOutput("busy_cycles", nb, busy);
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int lat, busy;
        modelOp(op, a, b, e, lat, busy);
        scoreboard.push_back(e);
        issue(op, a, b);
        waitDone(lat, busy);
    endtask

    // Compares HI/LO/DivZero against the oldest queued expectation on every Done pulse.
    always @(negedge i_clk) begin
        exp_t e;
        if (o_con_DivZero && !o_con_Done) checkOutput("dz_without_done", 64'd1, 64'd0);
        if (o_con_Done) begin
            if (scoreboard.size() == 0) begin
                checkOutput("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = scoreboard.pop_front();
                checkOutput("hi", {32'd0, o_data_Hi}, {32'd0, e.hi});
                checkOutput("lo", {32'd0, o_data_Lo}, {32'd0, e.lo});
                checkOutput("divzero", {63'd0, o_con_DivZero}, {63'd0, e.dz});
                checkOutput("busy_at_done", {63'd0, o_con_Busy}, 64'd0);
            end
        end
    end

    initial begin
        exp_t e;
        int lat, busy, k;
        logic [2:0] rop;
        logic [31:0] ra, rb;
        total = 0;
        bad = 0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        i_rst = 1'b1;
        i_con_Start = 1'b0;
        i_con_Op = 3'd0;
        i_data_A = 32'd0;
        i_data_B = 32'd0;
        #1;
        checkOutput("rst_busy", {63'd0, o_con_Busy}, 64'd0);
        checkOutput("rst_done", {63'd0, o_con_Done}, 64'd0);
        checkOutput("rst_dz", {63'd0, o_con_DivZero}, 64'd0);
        checkOutput("rst_hi", {32'd0, o_data_Hi}, 64'd0);
        checkOutput("rst_lo", {32'd0, o_data_Lo}, 64'd0);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;

        applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        applyStimulus(3'd0, 32'hFFFFFFFD, 32'd5);
        applyStimulus(3'd2, 32'hFFFFFFF9, 32'd2);
        applyStimulus(3'd3, 32'd7, 32'd2);
        applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF);
        applyStimulus(3'd0, 32'h80000000, 32'h80000000);
        applyStimulus(3'd4, 32'h1234, 32'd0);
        applyStimulus(3'd5, 32'h5678, 32'd0);
        applyStimulus(3'd3, 32'd10, 32'd0);
        applyStimulus(3'd2, 32'hDEADBEEF, 32'd0);

        // Reserved opcodes must be ignored entirely.
        issue(3'd6, 32'hAAAA5555, 32'd3);
        issue(3'd7, 32'h5555AAAA, 32'd3);
        repeat (3) @(negedge i_clk);
        checkOutput("reserved_hi", {32'd0, o_data_Hi}, {32'd0, model_hi});
        checkOutput("reserved_lo", {32'd0, o_data_Lo}, {32'd0, model_lo});

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : $urandom;
            applyStimulus(rop, ra, rb);
        end

        // Start while busy must not disturb the in-flight multiply.
`ifdef MULDIV_EARLY_TERM_EN
        k = 2;
`else
        k = 5;
`endif
        modelOp(3'd0, 32'd6, 32'd7, e, lat, busy);
        scoreboard.push_back(e);
        issue(3'd0, 32'd6, 32'd7);
        repeat (k - 1) @(posedge i_clk);
        #1;
        i_con_Start = 1'b1;
        i_con_Op = 3'd2;
        i_data_A = 32'd100;
        i_data_B = 32'd3;
        @(posedge i_clk);
        #1;
        i_con_Start = 1'b0;
        waitDone(lat - k, busy - k);
        checkOutput("overlap_lo", {32'd0, o_data_Lo}, 64'd42);
        repeat (3) @(negedge i_clk);

        // Reset in the middle of a divide loses it without a later Done.
        modelOp(3'd3, 32'hFFFF0000, 32'd3, e, lat, busy);
        scoreboard.push_back(e);
        issue(3'd3, 32'hFFFF0000, 32'd3);
        repeat (10) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        checkOutput("midrst_busy", {63'd0, o_con_Busy}, 64'd0);
        checkOutput("midrst_done", {63'd0, o_con_Done}, 64'd0);
        checkOutput("midrst_hi", {32'd0, o_data_Hi}, 64'd0);
        checkOutput("midrst_lo", {32'd0, o_data_Lo}, 64'd0);
        scoreboard.delete();
        model_hi = 32'd0;
        model_lo = 32'd0;
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (40) @(negedge i_clk);
        checkOutput("post_rst_idle", {63'd0, o_con_Busy}, 64'd0);
        applyStimulus(3'd3, 32'd7, 32'd2);

        repeat (2) @(negedge i_clk);
        checkOutput("sb_empty", scoreboard.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
